// File: rtl/spi_sine_2ch.sv
`timescale 1ns/1ps
// Purpose: sine-wave source for a dual-channel 12-bit SPI DAC; each start writes the current
//          sample to channel A, then channel B, steps the ROM address and pulses end_o.
// Latency: cs_o falls 2 clocks after sts_i is sampled; about 272 clocks per transaction.
// Flow control: none; sts_i is only looked at in IDLE, so strobes in any other state are dropped.
//
// Ports:
//   clk_i  - system clock
//   rst_i  - asynchronous active-high reset
//   sts_i  - start strobe, sampled in IDLE
//   mosi_o - SPI data, MSB first
//   sck_o  - SPI clock, mode 0, idle low
//   cs_o   - SPI chip select, active low
//   end_o  - one-cycle pulse after both channel frames
module spi_sine_2ch #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 12,
  parameter int DIV_HALF = 4,
  parameter int CS_GAP   = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sts_i,
  output logic mosi_o,
  output logic sck_o,
  output logic cs_o,
  output logic end_o
);

  localparam int FRAME_W = DATA_W + 4;
  localparam int DIV_W   = $clog2(DIV_HALF + 1);
  localparam int GAP_W   = $clog2(CS_GAP + 1);
  localparam int PH_W    = $clog2(2 * FRAME_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * FRAME_W);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SEND_A, S_GAP, S_SEND_B, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   sample_q;
  logic [GAP_W-1:0]    gap_cnt;
  logic                spi_start, ch_b, spi_done;
  logic [FRAME_W-1:0]  frame_word;

  logic                busy_q, sck_q;
  logic [FRAME_W-1:0]  sh_q;
  logic [PH_W-1:0]     ph_q;
  logic [DIV_W-1:0]    div_q;

  // First quarter of round(2048 + 2047*sin(2*pi*k/256)), k = 0..64.
  function automatic logic [11:0] sine_quarter(input logic [6:0] k);
    case (k)
      7'd0:  sine_quarter = 12'd2048; 7'd1:  sine_quarter = 12'd2098; 7'd2:  sine_quarter = 12'd2148; 7'd3:  sine_quarter = 12'd2199;
      7'd4:  sine_quarter = 12'd2249; 7'd5:  sine_quarter = 12'd2299; 7'd6:  sine_quarter = 12'd2348; 7'd7:  sine_quarter = 12'd2398;
      7'd8:  sine_quarter = 12'd2447; 7'd9:  sine_quarter = 12'd2497; 7'd10: sine_quarter = 12'd2545; 7'd11: sine_quarter = 12'd2594;
      7'd12: sine_quarter = 12'd2642; 7'd13: sine_quarter = 12'd2690; 7'd14: sine_quarter = 12'd2738; 7'd15: sine_quarter = 12'd2785;
      7'd16: sine_quarter = 12'd2831; 7'd17: sine_quarter = 12'd2878; 7'd18: sine_quarter = 12'd2923; 7'd19: sine_quarter = 12'd2968;
      7'd20: sine_quarter = 12'd3013; 7'd21: sine_quarter = 12'd3057; 7'd22: sine_quarter = 12'd3100; 7'd23: sine_quarter = 12'd3143;
      7'd24: sine_quarter = 12'd3185; 7'd25: sine_quarter = 12'd3227; 7'd26: sine_quarter = 12'd3267; 7'd27: sine_quarter = 12'd3307;
      7'd28: sine_quarter = 12'd3347; 7'd29: sine_quarter = 12'd3385; 7'd30: sine_quarter = 12'd3423; 7'd31: sine_quarter = 12'd3459;
      7'd32: sine_quarter = 12'd3495; 7'd33: sine_quarter = 12'd3531; 7'd34: sine_quarter = 12'd3565; 7'd35: sine_quarter = 12'd3598;
      7'd36: sine_quarter = 12'd3630; 7'd37: sine_quarter = 12'd3662; 7'd38: sine_quarter = 12'd3692; 7'd39: sine_quarter = 12'd3722;
      7'd40: sine_quarter = 12'd3750; 7'd41: sine_quarter = 12'd3777; 7'd42: sine_quarter = 12'd3804; 7'd43: sine_quarter = 12'd3829;
      7'd44: sine_quarter = 12'd3853; 7'd45: sine_quarter = 12'd3876; 7'd46: sine_quarter = 12'd3898; 7'd47: sine_quarter = 12'd3919;
      7'd48: sine_quarter = 12'd3939; 7'd49: sine_quarter = 12'd3958; 7'd50: sine_quarter = 12'd3975; 7'd51: sine_quarter = 12'd3992;
      7'd52: sine_quarter = 12'd4007; 7'd53: sine_quarter = 12'd4021; 7'd54: sine_quarter = 12'd4034; 7'd55: sine_quarter = 12'd4045;
      7'd56: sine_quarter = 12'd4056; 7'd57: sine_quarter = 12'd4065; 7'd58: sine_quarter = 12'd4073; 7'd59: sine_quarter = 12'd4080;
      7'd60: sine_quarter = 12'd4085; 7'd61: sine_quarter = 12'd4089; 7'd62: sine_quarter = 12'd4093; 7'd63: sine_quarter = 12'd4094;
      default: sine_quarter = 12'd4095;
    endcase
  endfunction

  // Full table from quarter-wave symmetry: addr[6] mirrors the index,
  // addr[7] selects the negative half (4096 - value).
  logic [6:0]  rom_k;
  logic [11:0] rom_q, rom_dat;
  always_comb begin
    rom_k   = addr_q[6] ? 7'(7'd64 - {1'b0, addr_q[5:0]}) : {1'b0, addr_q[5:0]};
    rom_q   = sine_quarter(rom_k);
    rom_dat = addr_q[7] ? 12'(13'd4096 - {1'b0, rom_q}) : rom_q;
  end

  // Sequencing FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Sequencing FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (sts_i) state_d = S_FETCH;
      S_FETCH:  state_d = S_SEND_A;
      S_SEND_A: if (spi_done) state_d = S_GAP;
      S_GAP:    if (gap_cnt == GAP_LAST) state_d = S_SEND_B;
      S_SEND_B: if (spi_done) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Sequencing FSM: outputs. The engine is idle only on the first cycle of
  // a SEND state (it drops busy on the same edge that leaves the state),
  // so this yields exactly one start per frame.
  always_comb begin
    spi_start = 1'b0;
    ch_b      = 1'b0;
    end_o     = 1'b0;
    case (state_q)
      S_SEND_A: spi_start = !busy_q;
      S_SEND_B: begin spi_start = !busy_q; ch_b = 1'b1; end
      S_DONE:   end_o = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: sample latch, gap timer, address counter (wraps naturally)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      sample_q <= '0;
      gap_cnt  <= '0;
    end else begin
      if (state_q == S_FETCH) sample_q <= rom_dat;
      if (state_q == S_DONE)  addr_q   <= addr_q + 1'b1;
      gap_cnt <= (state_q == S_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  // Channel mux: {A/B select, buffered=0, gain 1x, active}
  assign frame_word = {ch_b, 1'b0, 1'b1, 1'b1, sample_q};

  // SPI engine. ph_q counts SCK half-periods: odd phases drive SCK high,
  // entering an even phase drops SCK and shifts the next bit out. One extra
  // half-period after the last falling edge closes the frame (33 in total).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      sck_q  <= 1'b0;
      sh_q   <= '0;
      ph_q   <= '0;
      div_q  <= '0;
    end else if (!busy_q) begin
      if (spi_start) begin
        busy_q <= 1'b1;
        sh_q   <= frame_word;
        ph_q   <= '0;
        div_q  <= '0;
      end
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
      if (ph_q == PH_LAST) begin
        busy_q <= 1'b0;
      end else begin
        ph_q  <= ph_q + 1'b1;
        sck_q <= ~ph_q[0];
        if (ph_q[0]) sh_q <= {sh_q[FRAME_W-2:0], 1'b0};
      end
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign spi_done = busy_q && (div_q == DIV_LAST) && (ph_q == PH_LAST);
  assign cs_o     = ~busy_q;
  assign sck_o    = sck_q;
  // The shift register is all-zero outside a frame, so MOSI idles low.
  assign mosi_o   = sh_q[FRAME_W-1];

endmodule

// File: tb/tb_spi_sine_2ch.sv
`timescale 1ns/1ps
module tb_spi_sine_2ch;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic sts_i = 1'b0;
  logic mosi_o, sck_o, cs_o, end_o;

  int n_checks = 0;
  int n_fail   = 0;

  spi_sine_2ch #(.ADDR_W(8), .DATA_W(12), .DIV_HALF(4), .CS_GAP(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sts_i (sts_i),
    .mosi_o(mosi_o),
    .sck_o (sck_o),
    .cs_o  (cs_o),
    .end_o (end_o)
  );

  always #5 clk_i = ~clk_i;

  // SPI slave model: captures MOSI on SCK rising edges inside cs_o-low windows
  logic [15:0] sh;
  logic [15:0] wq[$];
  int          bq[$];
  int          lq[$];
  int bits = 0, low_cnt = 0, high_cnt = 0, last_gap = 0, falls = 0;
  int end_cnt = 0, sck_out_cnt = 0;
  logic prev_sck = 1'b0, prev_cs = 1'b1;

  initial begin : monitor
    sh = '0;
    forever begin
      @(negedge clk_i);
      if (end_o) end_cnt++;
      if (cs_o && sck_o) sck_out_cnt++;
      if (prev_cs && !cs_o) begin
        sh = '0; bits = 0; low_cnt = 0; last_gap = high_cnt; falls++;
      end
      if (!cs_o) begin
        low_cnt++;
        if (sck_o && !prev_sck) begin sh = {sh[14:0], mosi_o}; bits++; end
      end
      if (!prev_cs && cs_o) begin
        wq.push_back(sh); bq.push_back(bits); lq.push_back(low_cnt); high_cnt = 0;
      end
      if (cs_o) high_cnt++;
      prev_sck = sck_o;
      prev_cs  = cs_o;
    end
  end

  task automatic clr_frames();
    wq.delete(); bq.delete(); lq.delete();
  endtask

  task automatic run_txn(output bit timeout);
    int c;
    clr_frames();
    @(negedge clk_i); sts_i = 1'b1;
    @(negedge clk_i); sts_i = 1'b0;
    c = 0;
    while (!end_o && c < 1000) begin @(negedge clk_i); c++; end
    timeout = !end_o;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; sts_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_checks++; if (cs_o !== 1'b1)   begin n_fail++; $display("FAIL reset_cs: got %b want 1", cs_o); end
    n_checks++; if (sck_o !== 1'b0)  begin n_fail++; $display("FAIL reset_sck: got %b want 0", sck_o); end
    n_checks++; if (mosi_o !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi_o); end
    n_checks++; if (end_o !== 1'b0)  begin n_fail++; $display("FAIL reset_end: got %b want 0", end_o); end
    rst_i = 1'b0;
    repeat (20) @(negedge clk_i);
    n_checks++; if (falls !== 0 || end_cnt !== 0 || cs_o !== 1'b1)
      begin n_fail++; $display("FAIL idle_quiet: falls=%0d ends=%0d cs=%b want 0 0 1", falls, end_cnt, cs_o); end
  endtask

  task automatic test_single();
    int c, e0;
    clr_frames(); e0 = end_cnt;
    @(negedge clk_i); sts_i = 1'b1;
    @(posedge clk_i); #1 sts_i = 1'b0;
    n_checks++; if (cs_o !== 1'b1) begin n_fail++; $display("FAIL lat_e0: cs=%b want 1", cs_o); end
    @(posedge clk_i); #1;
    n_checks++; if (cs_o !== 1'b1) begin n_fail++; $display("FAIL lat_e1: cs=%b want 1", cs_o); end
    @(posedge clk_i); #1;
    n_checks++; if ({cs_o, sck_o, mosi_o} !== 3'b000)
      begin n_fail++; $display("FAIL lat_e2: cs/sck/mosi=%b want 000", {cs_o, sck_o, mosi_o}); end
    c = 0;
    while (!end_o && c < 1000) begin @(negedge clk_i); c++; end
    n_checks++; if (end_o !== 1'b1 || c >= 400)
      begin n_fail++; $display("FAIL single_end: end=%b cycles=%0d want 1 and <400", end_o, c); end
    @(negedge clk_i);
    n_checks++; if (wq.size() != 2 || wq[0] !== 16'h3800 || wq[1] !== 16'hB800)
      begin n_fail++; $display("FAIL single_words: n=%0d w=%p want 3800 b800", wq.size(), wq); end
    n_checks++; if (bq.size() != 2 || bq[0] != 16 || bq[1] != 16)
      begin n_fail++; $display("FAIL single_sck: pulses=%p want 16 16", bq); end
    n_checks++; if (lq.size() != 2 || lq[0] != 132 || lq[1] != 132)
      begin n_fail++; $display("FAIL frame_len: cycles=%p want 132 132", lq); end
    n_checks++; if (last_gap < 4) begin n_fail++; $display("FAIL cs_gap: got %0d want >=4", last_gap); end
    n_checks++; if (end_cnt - e0 != 1) begin n_fail++; $display("FAIL single_endcnt: got %0d want 1", end_cnt - e0); end
    n_checks++; if (sck_out_cnt != 0) begin n_fail++; $display("FAIL sck_idle: got %0d want 0", sck_out_cnt); end
  endtask

  // Transactions 2..257; the single test above was number 1 (address 0).
  task automatic test_sequence();
    bit to;
    int bad;
    logic [11:0] exp;
    bad = 0;
    for (int t = 2; t <= 257; t++) begin
      run_txn(to);
      if (to || wq.size() != 2) bad++;
      if (t == 65 || t == 129 || t == 193 || t == 257) begin
        exp = (t == 65) ? 12'hFFF : (t == 193) ? 12'h001 : 12'h800;
        n_checks++; if (to || wq.size() != 2 || wq[0] !== {4'h3, exp} || wq[1] !== {4'hB, exp})
          begin n_fail++; $display("FAIL seq_txn%0d: w=%p want %h %h", t, wq, {4'h3, exp}, {4'hB, exp}); end
      end
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL seq_txns: bad=%0d want 0", bad); end
  endtask

  task automatic test_ignore_sts();
    int c, e0, f0;
    bit to;
    clr_frames(); e0 = end_cnt; f0 = falls;
    @(negedge clk_i); sts_i = 1'b1;
    @(negedge clk_i); sts_i = 1'b0;
    c = 0; while (falls < f0 + 1 && c < 400) begin @(negedge clk_i); c++; end
    repeat (10) @(negedge clk_i); sts_i = 1'b1;
    @(negedge clk_i); sts_i = 1'b0;
    c = 0; while (falls < f0 + 2 && c < 400) begin @(negedge clk_i); c++; end
    repeat (10) @(negedge clk_i); sts_i = 1'b1;
    @(negedge clk_i); sts_i = 1'b0;
    c = 0; while (!end_o && c < 400) begin @(negedge clk_i); c++; end
    repeat (30) @(negedge clk_i);
    n_checks++; if (end_cnt - e0 != 1 || falls != f0 + 2)
      begin n_fail++; $display("FAIL ign_count: ends=%0d frames=%0d want 1 2", end_cnt - e0, falls - f0); end
    n_checks++; if (wq.size() != 2 || wq[0] !== 16'h3832 || wq[1] !== 16'hB832)
      begin n_fail++; $display("FAIL ign_words: w=%p want 3832 b832", wq); end
    run_txn(to);
    n_checks++; if (to || wq.size() != 2 || wq[0] !== 16'h3864 || wq[1] !== 16'hB864)
      begin n_fail++; $display("FAIL ign_next: to=%b w=%p want 3864 b864", to, wq); end
  endtask

  task automatic test_back_to_back();
    int c, k, e0, f0;
    clr_frames(); e0 = end_cnt;
    @(negedge clk_i); sts_i = 1'b1;
    c = 0; while (!end_o && c < 600) begin @(negedge clk_i); c++; end
    k = 0;
    do begin @(negedge clk_i); k++; end while (cs_o && k < 20);
    n_checks++; if (k != 4) begin n_fail++; $display("FAIL b2b_turn: got %0d want 4", k); end
    c = 0; while (!end_o && c < 600) begin @(negedge clk_i); c++; end
    sts_i = 1'b0;
    @(negedge clk_i);
    f0 = falls;
    repeat (20) @(negedge clk_i);
    n_checks++; if (end_cnt - e0 != 2 || falls != f0)
      begin n_fail++; $display("FAIL b2b_count: ends=%0d extra=%0d want 2 0", end_cnt - e0, falls - f0); end
    n_checks++; if (wq.size() != 4 || wq[0] !== 16'h3897 || wq[1] !== 16'hB897 || wq[2] !== 16'h38C9 || wq[3] !== 16'hB8C9)
      begin n_fail++; $display("FAIL b2b_words: w=%p want 3897 b897 38c9 b8c9", wq); end
  endtask

  task automatic test_reset_mid();
    int c, e0, f0;
    bit to;
    clr_frames(); e0 = end_cnt; f0 = falls;
    @(negedge clk_i); sts_i = 1'b1;
    @(negedge clk_i); sts_i = 1'b0;
    c = 0; while (!(falls == f0 + 2 && bits >= 8) && c < 600) begin @(negedge clk_i); c++; end
    n_checks++; if (cs_o !== 1'b0 || falls != f0 + 2)
      begin n_fail++; $display("FAIL mid_pre: cs=%b frames=%0d want 0 2", cs_o, falls - f0); end
    #2 rst_i = 1'b1;
    #1;
    n_checks++; if ({cs_o, sck_o, mosi_o, end_o} !== 4'b1000)
      begin n_fail++; $display("FAIL mid_async: cs/sck/mosi/end=%b want 1000", {cs_o, sck_o, mosi_o, end_o}); end
    repeat (3) @(negedge clk_i); rst_i = 1'b0;
    repeat (20) @(negedge clk_i);
    n_checks++; if (end_cnt != e0 || cs_o !== 1'b1)
      begin n_fail++; $display("FAIL mid_noend: ends=%0d cs=%b want 0 1", end_cnt - e0, cs_o); end
    run_txn(to);
    n_checks++; if (to || wq.size() != 2 || wq[0] !== 16'h3800 || wq[1] !== 16'hB800)
      begin n_fail++; $display("FAIL mid_restart: to=%b w=%p want 3800 b800", to, wq); end
    n_checks++; if (sck_out_cnt != 0) begin n_fail++; $display("FAIL sck_outside: got %0d want 0", sck_out_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_ignore_sts();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
